gui_screen_sequencer: RTL and testbench
=======================================

# gui_screen_sequencer

Parametrised screen sequencer for the Snake VGA display. Drives the pixel-plot interface of the VGA adapter: draws a title screen, clears the play field with an optional border, idles during play, then draws a flashing game-over sequence and waits for restart. Generalises the fixed title/map/game-over GUI path with configurable resolution, colour depth, border mode and flash count/period. It also adds status outputs (`screen`, `busy`, `frame_done`) for the game controller.

## Interface

Parameters:
- `X_W`, 8: width of `x`; `SCREEN_W` ≤ 2^`X_W`.
- `Y_W`, 7: width of `y`; `SCREEN_H` ≤ 2^`Y_W`.
- `SCREEN_W`, 160: pixels per row, ≥ 2.
- `SCREEN_H`, 120: rows per frame, ≥ 2.
- `COLOUR_W`, 3: colour width.
- `TITLE_COLOUR`, 3'b001: title fill.
- `MAP_COLOUR`, 3'b000: play-field fill, also the "off" flash colour.
- `BORDER_COLOUR`, 3'b111: border pixel colour.
- `BORDER_EN`, 1: 1 = draw a 1-pixel border on the map, 0 = no border.
- `OVER_COLOUR`, 3'b100: game-over fill.
- `FLASH_COUNT`, 3: number of `OVER_COLOUR` frames, ≥ 1.
- `FLASH_HOLD`, 12_500_000: idle cycles between flash frames, ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level; leaves title wait or game-over wait.
- `isDead`, in, 1: level; snake died.
- `x`, out, `X_W`: pixel column.
- `y`, out, `Y_W`: pixel row.
- `colour`, out, `COLOUR_W`: pixel colour.
- `plot`, out, 1: write strobe; the adapter writes `colour` at (`x`,`y`) on every cycle `plot`=1.
- `screen`, out, 2: 0 = title, 1 = map, 2 = play, 3 = game over.
- `busy`, out, 1: high during any frame draw or flash hold.
- `frame_done`, out, 1: one-cycle pulse after the last pixel of each frame.

## Operation

- States:
  - BOOT: reset state only.
  - TITLE_DRAW, TITLE_WAIT.
  - MAP_DRAW.
  - PLAY.
  - OVER_DRAW, OVER_HOLD, OVER_WAIT.
- Raster engine, used by every DRAW state:
  - One pixel per cycle, `x` increments fastest.
  - Order: (0,0), (1,0) … (`SCREEN_W`-1,0), (0,1) … (`SCREEN_W`-1,`SCREEN_H`-1).
  - Exactly `SCREEN_W`·`SCREEN_H` plots per frame.
  - `x`/`y` return to 0 at frame end.
- BOOT → TITLE_DRAW unconditionally on the first edge after reset release.
- TITLE_DRAW: colour = `TITLE_COLOUR`. Frame end → TITLE_WAIT.
- TITLE_WAIT: `start`=1 → MAP_DRAW.
- MAP_DRAW:
  - With `BORDER_EN`=1, colour = `BORDER_COLOUR` when x=0, x=`SCREEN_W`-1, y=0 or y=`SCREEN_H`-1.
  - All other pixels are `MAP_COLOUR`.
  - Frame end → PLAY.
- PLAY: `plot`=0. `isDead`=1 → OVER_DRAW with flash index k=0.
- OVER_DRAW: colour = `OVER_COLOUR` if k is even, else `MAP_COLOUR`. Frame end:
  - k = 2·`FLASH_COUNT`-2 → OVER_WAIT (the final frame is always `OVER_COLOUR`).
  - Otherwise → OVER_HOLD.
- OVER_HOLD: counts exactly `FLASH_HOLD` cycles with `plot`=0, then k←k+1 and → OVER_DRAW.
- OVER_WAIT: `start`=1 → MAP_DRAW (restart without the title).
- Ignored inputs:
  - `start` is ignored in every state except TITLE_WAIT and OVER_WAIT.
  - `isDead` is ignored except in PLAY.
  - `start` and `isDead` both high in PLAY → OVER_DRAW.
- `screen` mapping:
  - TITLE_DRAW/TITLE_WAIT → 0.
  - MAP_DRAW → 1.
  - PLAY → 2.
  - OVER_* → 3.
  - BOOT → 0.
- Width rules:
  - Hold counter width is clog2(`FLASH_HOLD`+1).
  - Flash index width is clog2(2·`FLASH_COUNT`).
  - End-of-row and end-of-frame compares use `SCREEN_W`-1 and `SCREEN_H`-1 at full `X_W`/`Y_W` width, with no wrap through 2^`X_W`.

## Timing

- All outputs are registered. `x`, `y`, `colour` and `plot` are mutually aligned in the same cycle.
- Reset (`reset`=0) acts asynchronously. Outputs take these values immediately and hold them while reset is low:
  - `x`=0, `y`=0, `colour`=0.
  - `plot`=0, `busy`=0, `frame_done`=0.
  - `screen`=0, state BOOT.
- Reset mid-frame abandons the frame with no further plots. After release the sequence restarts from BOOT.
- First title pixel (0,0) with `plot`=1 appears in the cycle after the first post-reset edge, i.e. the second cycle after release.
- `start` sampled high at edge n in a WAIT state → pixel (0,0) with `plot`=1 in cycle n+1.
- `isDead` sampled high at edge n in PLAY → game-over pixel (0,0) in cycle n+1.
- Each frame holds `plot` high for `SCREEN_W`·`SCREEN_H` consecutive cycles.
- `frame_done` is high in the single cycle after the last pixel, with `plot`=0 in that cycle and the next state already entered.
- `busy` is 1 throughout the DRAW and OVER_HOLD states, including the `frame_done` cycle of a draw→draw-related transition. It is 0 in WAIT, PLAY and BOOT.
- Gap between flash frames: exactly `FLASH_HOLD`+1 `plot`=0 cycles (the `frame_done` cycle plus the hold).

## Test plan

Bench parameters: `SCREEN_W`=4, `SCREEN_H`=3, `FLASH_COUNT`=2, `FLASH_HOLD`=5, other parameters default.

1. Release reset, hold `start`=0:
   - 12 consecutive plots (0,0)…(3,2) in raster order, colour 3'b001.
   - `frame_done` pulses once.
   - `screen`=0, then `plot` stays 0 indefinitely.
2. Pulse `start` in TITLE_WAIT:
   - 12 plots; (1,1) and (2,1) are 3'b000, the other 10 are 3'b111.
   - Then `screen`=2, `busy`=0.
3. Assert `isDead` in PLAY:
   - Frames OVER (3'b100), MAP (3'b000), OVER (3'b100), each 12 plots.
   - Each gap between frames is 6 `plot`=0 cycles.
   - 3 `frame_done` pulses; ends in OVER_WAIT with `screen`=3.
4. Ignored and simultaneous inputs:
   - Toggle `start` during every draw and `isDead` during title wait and map draw: no state change, plot count unchanged.
   - `start`=`isDead`=1 in PLAY → game-over draw.
5. Assert `reset` low at pixel 7 of the map draw:
   - Same cycle: `plot`=0, `x`=`y`=0, `screen`=0.
   - After release the title redraws from (0,0).
6. `start` in OVER_WAIT with `BORDER_EN`=0 build:
   - Map redraws with all 12 pixels 3'b000.
   - No title frame is drawn, then PLAY.

Source files
------------

// File: rtl/gui_screen_sequencer.sv
// Screen sequencer for the Snake VGA display: title, map with optional border,
// play idle, then a flashing game-over sequence that waits for a restart.
module gui_screen_sequencer #(
    parameter int                  X_W           = 8,
    parameter int                  Y_W           = 7,
    parameter int                  SCREEN_W      = 160,
    parameter int                  SCREEN_H      = 120,
    parameter int                  COLOUR_W      = 3,
    parameter logic [COLOUR_W-1:0] TITLE_COLOUR  = 3'b001,
    parameter logic [COLOUR_W-1:0] MAP_COLOUR    = 3'b000,
    parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111,
    parameter bit                  BORDER_EN     = 1'b1,
    parameter logic [COLOUR_W-1:0] OVER_COLOUR   = 3'b100,
    parameter int                  FLASH_COUNT   = 3,
    parameter int                  FLASH_HOLD    = 12_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                isDead,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [1:0]          screen,
    output logic                busy,
    output logic                frame_done
);

    localparam int H_W = $clog2(FLASH_HOLD + 1);
    localparam int K_W = $clog2(2 * FLASH_COUNT);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(FLASH_HOLD);
    localparam logic [K_W-1:0] K_LAST = K_W'(2 * FLASH_COUNT - 2);

    typedef enum logic [2:0] {
        S_BOOT,
        S_TITLE_DRAW,
        S_TITLE_WAIT,
        S_MAP_DRAW,
        S_PLAY,
        S_OVER_DRAW,
        S_OVER_HOLD,
        S_OVER_WAIT
    } state_t;

    state_t              r_state;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic [1:0]          r_screen;
    logic                r_busy;
    logic                r_frameDone;
    logic [H_W-1:0]      r_hold;
    logic [K_W-1:0]      r_k;

    state_t              w_nextState;
    logic [X_W-1:0]      w_nextX;
    logic [Y_W-1:0]      w_nextY;
    logic [COLOUR_W-1:0] w_nextColour;
    logic                w_nextPlot;
    logic [1:0]          w_nextScreen;
    logic                w_nextBusy;
    logic                w_nextFrameDone;
    logic [H_W-1:0]      w_nextHold;
    logic [K_W-1:0]      w_nextK;
    logic                w_frameLast;
    logic                w_beginFrame;
    logic                w_advance;
    logic                w_frameEnd;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_BOOT;
            r_x         <= '0;
            r_y         <= '0;
            r_colour    <= '0;
            r_plot      <= 1'b0;
            r_screen    <= 2'd0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_hold      <= '0;
            r_k         <= '0;
        end else begin
            r_state     <= w_nextState;
            r_x         <= w_nextX;
            r_y         <= w_nextY;
            r_colour    <= w_nextColour;
            r_plot      <= w_nextPlot;
            r_screen    <= w_nextScreen;
            r_busy      <= w_nextBusy;
            r_frameDone <= w_nextFrameDone;
            r_hold      <= w_nextHold;
            r_k         <= w_nextK;
        end
    end

    // Next state, raster pointer and the registered outputs for the next cycle.
    always_comb begin
        w_nextState     = r_state;
        w_nextX         = r_x;
        w_nextY         = r_y;
        w_nextColour    = r_colour;
        w_nextPlot      = 1'b0;
        w_nextScreen    = 2'd0;
        w_nextBusy      = 1'b0;
        w_nextFrameDone = 1'b0;
        w_nextHold      = r_hold;
        w_nextK         = r_k;
        w_beginFrame    = 1'b0;
        w_advance       = 1'b0;
        w_frameEnd      = 1'b0;
        w_frameLast     = (r_x == X_LAST) && (r_y == Y_LAST);

        case (r_state)
            S_BOOT: begin
                w_nextState  = S_TITLE_DRAW;
                w_beginFrame = 1'b1;
            end
            S_TITLE_DRAW: begin
                if (w_frameLast) begin
                    w_nextState = S_TITLE_WAIT;
                    w_frameEnd  = 1'b1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_TITLE_WAIT: begin
                if (start) begin
                    w_nextState  = S_MAP_DRAW;
                    w_beginFrame = 1'b1;
                end
            end
            S_MAP_DRAW: begin
                if (w_frameLast) begin
                    w_nextState = S_PLAY;
                    w_frameEnd  = 1'b1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_PLAY: begin
                if (isDead) begin
                    w_nextState  = S_OVER_DRAW;
                    w_nextK      = '0;
                    w_beginFrame = 1'b1;
                end
            end
            S_OVER_DRAW: begin
                if (w_frameLast) begin
                    w_frameEnd = 1'b1;
                    if (r_k == K_LAST) begin
                        w_nextState = S_OVER_WAIT;
                    end else begin
                        w_nextState = S_OVER_HOLD;
                        w_nextHold  = '0;
                    end
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_OVER_HOLD: begin
                if (r_hold == H_LAST) begin
                    w_nextState  = S_OVER_DRAW;
                    w_nextK      = r_k + K_W'(1);
                    w_beginFrame = 1'b1;
                end else begin
                    w_nextHold = r_hold + H_W'(1);
                end
            end
            S_OVER_WAIT: begin
                if (start) begin
                    w_nextState  = S_MAP_DRAW;
                    w_beginFrame = 1'b1;
                end
            end
            default: begin
                w_nextState = S_BOOT;
            end
        endcase

        if (w_beginFrame) begin
            w_nextX    = '0;
            w_nextY    = '0;
            w_nextPlot = 1'b1;
        end else if (w_advance) begin
            w_nextPlot = 1'b1;
            if (r_x == X_LAST) begin
                w_nextX = '0;
                w_nextY = r_y + Y_W'(1);
            end else begin
                w_nextX = r_x + X_W'(1);
            end
        end else if (w_frameEnd) begin
            w_nextX         = '0;
            w_nextY         = '0;
            w_nextFrameDone = 1'b1;
        end

        case (w_nextState)
            S_TITLE_DRAW: begin
                w_nextColour = TITLE_COLOUR;
            end
            S_MAP_DRAW: begin
                if (BORDER_EN && ((w_nextX == '0) || (w_nextX == X_LAST) ||
                                  (w_nextY == '0) || (w_nextY == Y_LAST))) begin
                    w_nextColour = BORDER_COLOUR;
                end else begin
                    w_nextColour = MAP_COLOUR;
                end
            end
            S_OVER_DRAW: begin
                w_nextColour = w_nextK[0] ? MAP_COLOUR : OVER_COLOUR;
            end
            default: begin
                w_nextColour = r_colour;
            end
        endcase

        case (w_nextState)
            S_MAP_DRAW:                             w_nextScreen = 2'd1;
            S_PLAY:                                 w_nextScreen = 2'd2;
            S_OVER_DRAW, S_OVER_HOLD, S_OVER_WAIT:  w_nextScreen = 2'd3;
            default:                                w_nextScreen = 2'd0;
        endcase

        w_nextBusy = (w_nextState == S_TITLE_DRAW) || (w_nextState == S_MAP_DRAW) ||
                     (w_nextState == S_OVER_DRAW)  || (w_nextState == S_OVER_HOLD);
    end

    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign screen     = r_screen;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_gui_screen_sequencer.sv
// Bench for gui_screen_sequencer: two builds (border on/off) share the same
// stimulus and are checked cycle by cycle against an expected-trace queue.
module tb_gui_screen_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FC = 2;
    localparam int FH = 5;

    localparam int K_NONE  = 0;
    localparam int K_ZERO  = 1;
    localparam int K_TITLE = 2;
    localparam int K_MAP   = 3;
    localparam int K_OVER  = 4;
    localparam int K_OFF   = 5;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       isDead = 1'b0;

    logic [7:0] xB, xN;
    logic [6:0] yB, yN;
    logic [2:0] colB, colN;
    logic       plotB, plotN;
    logic [1:0] scrB, scrN;
    logic       busyB, busyN;
    logic       doneB, doneN;

    typedef struct {
        bit plot;
        int x;
        int y;
        int kind;
        int scr;
        bit busy;
        bit done;
    } rec_t;

    rec_t expQ[$];
    int   idleScreen  = 0;
    int   passCount   = 0;
    int   failCount   = 0;
    int   totalCount  = 0;

    gui_screen_sequencer #(
        .SCREEN_W(W), .SCREEN_H(H), .FLASH_COUNT(FC), .FLASH_HOLD(FH), .BORDER_EN(1'b1)
    ) dutBorder (
        .clk(clk), .reset(reset), .start(start), .isDead(isDead),
        .x(xB), .y(yB), .colour(colB), .plot(plotB),
        .screen(scrB), .busy(busyB), .frame_done(doneB)
    );

    gui_screen_sequencer #(
        .SCREEN_W(W), .SCREEN_H(H), .FLASH_COUNT(FC), .FLASH_HOLD(FH), .BORDER_EN(1'b0)
    ) dutPlain (
        .clk(clk), .reset(reset), .start(start), .isDead(isDead),
        .x(xN), .y(yN), .colour(colN), .plot(plotN),
        .screen(scrN), .busy(busyN), .frame_done(doneN)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case the sequence never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] expColour(int kind, int px, int py, bit border);
        case (kind)
            K_TITLE: return 3'b001;
            K_MAP:   return (border && (px == 0 || px == W - 1 || py == 0 || py == H - 1))
                            ? 3'b111 : 3'b000;
            K_OVER:  return 3'b100;
            K_OFF:   return 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic rec_t idleRec();
        return '{1'b0, 0, 0, K_NONE, idleScreen, 1'b0, 1'b0};
    endfunction

    function automatic rec_t resetRec();
        return '{1'b0, 0, 0, K_ZERO, 0, 1'b0, 1'b0};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(rec_t r);
        check("plotB",  32'(plotB), 32'(r.plot));
        check("plotN",  32'(plotN), 32'(r.plot));
        check("xB",     32'(xB),    32'(r.x));
        check("xN",     32'(xN),    32'(r.x));
        check("yB",     32'(yB),    32'(r.y));
        check("yN",     32'(yN),    32'(r.y));
        check("screenB", 32'(scrB), 32'(r.scr));
        check("screenN", 32'(scrN), 32'(r.scr));
        check("busyB",  32'(busyB), 32'(r.busy));
        check("busyN",  32'(busyN), 32'(r.busy));
        check("doneB",  32'(doneB), 32'(r.done));
        check("doneN",  32'(doneN), 32'(r.done));
        if (r.kind != K_NONE) begin
            check("colourB", 32'(colB), 32'(expColour(r.kind, r.x, r.y, 1'b1)));
            check("colourN", 32'(colN), 32'(expColour(r.kind, r.x, r.y, 1'b0)));
        end
    endtask

    // One full frame in raster order followed by its frame_done cycle.
    task automatic pushFrame(int kind, int scr, int doneScr, bit doneBusy);
        for (int py = 0; py < H; py++) begin
            for (int px = 0; px < W; px++) begin
                expQ.push_back('{1'b1, px, py, kind, scr, 1'b1, 1'b0});
            end
        end
        expQ.push_back('{1'b0, 0, 0, K_NONE, doneScr, doneBusy, 1'b1});
    endtask

    task automatic pushGameOver();
        for (int k = 0; k <= 2 * FC - 2; k++) begin
            pushFrame((k % 2 == 0) ? K_OVER : K_OFF, 3, 3, k != 2 * FC - 2);
            if (k != 2 * FC - 2) begin
                for (int h = 0; h < FH; h++) begin
                    expQ.push_back('{1'b0, 0, 0, K_NONE, 3, 1'b1, 1'b0});
                end
            end
        end
        idleScreen = 3;
    endtask

    // Advance n cycles, check each against the trace, and wiggle inputs that
    // the current state is supposed to ignore.
    task automatic applyStimulus(int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) r = expQ.pop_front();
            else                 r = idleRec();
            checkOutput(r);
            if (r.plot || (r.busy && !r.done)) begin
                start  = 1'($urandom_range(0, 1));
                isDead = 1'($urandom_range(0, 1));
            end else if (idleScreen == 2) begin
                start  = 1'($urandom_range(0, 1));
                isDead = 1'b0;
            end else begin
                start  = 1'b0;
                isDead = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drainQueue();
        int guard = 0;
        while (expQ.size() > 0 && guard < 200) begin
            applyStimulus(1);
            guard++;
        end
        check("drainTimeout", 32'(expQ.size()), 32'd0);
    endtask

    task automatic assertReset();
        reset  = 1'b0;
        start  = 1'b0;
        isDead = 1'b0;
        #1;
        checkOutput(resetRec());
        expQ.delete();
        idleScreen = 0;
    endtask

    task automatic holdReset(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput(resetRec());
        end
    endtask

    task automatic releaseReset();
        reset = 1'b1;
        #1;
        checkOutput(idleRec());
        pushFrame(K_TITLE, 0, 0, 1'b0);
        idleScreen = 0;
    endtask

    task automatic pressStart();
        start = 1'b1;
        pushFrame(K_MAP, 1, 2, 1'b0);
        idleScreen = 2;
    endtask

    task automatic killSnake(bit alsoStart);
        isDead = 1'b1;
        start  = alsoStart;
        pushGameOver();
    endtask

    // Directed sequence: boot, title, map, play, game over, restart, mid-frame reset.
    initial begin
        #2;
        assertReset();
        holdReset(2);
        releaseReset();
        drainQueue();
        applyStimulus(int'($urandom_range(3, 8)));

        for (int g = 0; g < 2; g++) begin
            pressStart();
            drainQueue();
            applyStimulus(int'($urandom_range(2, 6)));
            killSnake(g == 1);
            drainQueue();
            applyStimulus(int'($urandom_range(2, 6)));
        end

        pressStart();
        applyStimulus(8);
        assertReset();
        holdReset(2);
        releaseReset();
        drainQueue();
        applyStimulus(3);

        pressStart();
        drainQueue();
        applyStimulus(2);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
